seq7_checker: RTL and testbench
===============================

Name: seq7_checker

Overview:
- Downstream consumer of the 7-state one-hot serial pattern generator; receives its 1-bit output stream `y[0]` on `din`.
- Acquires alignment to the 7-bit periodic pattern, confirms it over consecutive periods, then tracks it.
- Flags bit errors and loss of lock; provides a saturating error count for status and self-test.

Parameters:
- LOCK_FRAMES, default 2: consecutive error-free 7-bit periods in CHECK before `locked` asserts (1..15).
- UNLOCK_BAD, default 3: consecutive periods with at least one error in LOCKED before returning to HUNT (1..15).
- ERRW, default 16: width of `err_count`.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- din  in  1  serial pattern bit (generator `y[0]`)
- din_valid  in  1  `din` is sampled only on edges where this is high
- locked  out  1  high in LOCKED state
- phase  out  3  index (0..6) of the next expected pattern bit; 0 in HUNT
- bit_err  out  1  one-cycle pulse: mismatching bit accepted in CHECK or LOCKED
- frame_start  out  1  one-cycle pulse: a phase-6 bit was accepted in LOCKED (period boundary)
- err_count  out  ERRW  saturating count of bit errors accepted in LOCKED
- state_o  out  3  current state code, for debug

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Async assert; release is synchronous to `clk`.
- Reset values: state HUNT, window 0, fill 0, phase 0, good/bad counters 0, `locked`=0, `bit_err`=0, `frame_start`=0, `err_count`=0.
- Pattern, from the shared package: PAT[0..6] = 1,1,0,1,0,0,0.
- All outputs are registered; each reflects the bit accepted at the previous edge.
- When `din_valid`=0: every register holds; `bit_err` and `frame_start` are 0.
- Window `w[6:0]` shifts on every accepted bit in every state: `w[0]` is newest, `w[6]` is oldest.
- Fill counter saturates at 7 and is cleared only by reset.
- States are one-hot encoded: HUNT=3'b001, CHECK=3'b010, LOCKED=3'b100.
- HUNT:
  - On an accepted bit where fill (including this bit) ≥ 7 and the updated window satisfies `w[6-i]==PAT[i]` for all i: go to CHECK, phase=0, good=0.
  - Otherwise stay in HUNT.
  - No `bit_err` is generated in HUNT.
- CHECK:
  - Compare each accepted bit with PAT[phase]; phase then increments and wraps 6→0.
  - On a mismatch: `bit_err` pulses, go to HUNT, phase=0. `err_count` is unchanged.
  - At the phase-6 bit with no error this period: good+1.
  - When good reaches LOCK_FRAMES: go to LOCKED at that same edge, bad=0.
- LOCKED:
  - Compare each accepted bit as in CHECK; phase wraps.
  - On a mismatch: `bit_err` pulses, `err_count` increments (saturates at all-ones), period-error flag is set.
  - At the phase-6 bit: `frame_start` pulses.
    - If the period had an error (including this bit): bad+1, else bad=0.
    - If bad reaches UNLOCK_BAD: go to HUNT, phase=0, `locked`=0 next cycle. `frame_start`, `bit_err` and the `err_count` increment for that same bit still occur.
  - The period-error flag clears at each phase-6 bit.
- Simultaneous events: a mismatch on the phase-6 bit counts toward both the error tally and that period's bad status.
- Reset mid-operation: returns to reset values immediately, regardless of state.
- Re-acquisition after falling to HUNT reuses the current window; no refill is needed.

Decomposition:
- Package `seq7_pkg`:
  - `PAT_LEN`=7.
  - `PAT` constant, 7 bits, index-ordered.
  - `chk_state_t` one-hot enum (HUNT, CHECK, LOCKED).
  - Default LOCK_FRAMES and UNLOCK_BAD values.
- One sub-module, `seq7_err_counter`: ERRW-bit saturating counter with `inc` and async active-low clear.

Test Plan:
- Reset, then continuous valid stream 1,1,0,1,0,0,0 repeating → CHECK after the 7th bit, `locked`=1 after the 21st accepted bit, `frame_start` every 7 bits thereafter, `err_count`=0.
- Stream starting mid-pattern (0,1,0,0,0,1,1,…) → first match at the 12th bit, `locked` after the 26th, `phase` tracks correctly.
- While locked, invert one bit at phase 3 → one `bit_err` pulse, `err_count`=1, `locked` stays 1.
- While locked, one error in each of 3 consecutive periods → `locked` falls the cycle after the third period's phase-6 bit, `err_count`=3; clean stream afterwards → re-lock 14 bits after re-acquisition.
- Error in CHECK (2nd period) → `bit_err` pulse, return to HUNT, `err_count` unchanged.
- `din_valid` toggled 1/0 every cycle with a clean stream → same lock point counted in accepted bits; no state or output change on invalid cycles.
- Assert reset while locked → all outputs 0 asynchronously; a clean stream re-locks after 21 accepted bits.

Source files
------------

// File: rtl/seq7_pkg.sv
// Shared definitions for the 7-bit serial pattern checker.
// PAT[i] is the i-th bit of one period as emitted by the generator (index-ordered).
package seq7_pkg;

  localparam int unsigned PAT_LEN = 7;
  localparam logic [PAT_LEN-1:0] PAT = 7'b0001011;  // sequence 1,1,0,1,0,0,0

  localparam int unsigned LOCK_FRAMES_DEF = 2;
  localparam int unsigned UNLOCK_BAD_DEF  = 3;

  typedef enum logic [2:0] {
    StHunt   = 3'b001,
    StCheck  = 3'b010,
    StLocked = 3'b100
  } chk_state_t;

  // The shift window holds the newest bit in w[0], so a full aligned period
  // appears bit-reversed relative to PAT.
  function automatic logic [PAT_LEN-1:0] pat_window();
    logic [PAT_LEN-1:0] w;
    for (int i = 0; i < PAT_LEN; i++) begin
      w[PAT_LEN-1-i] = PAT[i];
    end
    return w;
  endfunction

  localparam logic [PAT_LEN-1:0] PAT_WIN = pat_window();

endpackage

// File: rtl/seq7_err_counter.sv
// Saturating bit-error counter.
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low clear
//   inc_i    count one error this cycle
//   count_o  current count, sticks at all-ones
module seq7_err_counter #(
  parameter int unsigned ERRW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  output logic [ERRW-1:0] count_o
);

  logic [ERRW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq7_checker.sv
// Alignment checker for the 7-bit periodic serial pattern.
// Hunts for the pattern in a 7-bit shift window, confirms it over LOCK_FRAMES clean
// periods, then tracks it, flagging bit errors and dropping lock after UNLOCK_BAD
// consecutive errored periods.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   din          serial pattern bit
//   din_valid    din is accepted only when high
//   locked       high while in LOCKED
//   phase        index of the next expected pattern bit (0 in HUNT)
//   bit_err      pulse: mismatching bit accepted in CHECK or LOCKED
//   frame_start  pulse: phase-6 bit accepted in LOCKED
//   err_count    saturating count of errors seen in LOCKED
//   state_o      one-hot state code
module seq7_checker
  import seq7_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int unsigned UNLOCK_BAD  = UNLOCK_BAD_DEF,
  parameter int unsigned ERRW        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            din,
  input  logic            din_valid,
  output logic            locked,
  output logic [2:0]      phase,
  output logic            bit_err,
  output logic            frame_start,
  output logic [ERRW-1:0] err_count,
  output logic [2:0]      state_o
);

  localparam logic [3:0] LockFramesW = 4'(LOCK_FRAMES);
  localparam logic [3:0] UnlockBadW  = 4'(UNLOCK_BAD);

  chk_state_t state_q, state_d;
  logic [PAT_LEN-1:0] win_q, win_d;
  logic [2:0] fill_q, fill_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic perr_q, perr_d;
  logic bit_err_q, bit_err_d;
  logic frame_start_q, frame_start_d;
  logic err_inc;

  logic mismatch, last_bit;
  logic [2:0] phase_inc;

  assign mismatch  = din ^ PAT[phase_q];
  assign last_bit  = (phase_q == 3'd6);
  assign phase_inc = last_bit ? 3'd0 : phase_q + 3'd1;

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    fill_d        = fill_q;
    phase_d       = phase_q;
    good_d        = good_q;
    bad_d         = bad_q;
    perr_d        = perr_q;
    bit_err_d     = 1'b0;
    frame_start_d = 1'b0;
    err_inc       = 1'b0;

    if (din_valid) begin
      win_d  = {win_q[PAT_LEN-2:0], din};
      fill_d = (fill_q == 3'd7) ? fill_q : fill_q + 3'd1;

      unique case (state_q)
        StHunt: begin
          if (fill_d == 3'd7 && win_d == PAT_WIN) begin
            state_d = StCheck;
            phase_d = 3'd0;
            good_d  = 4'd0;
          end
        end

        StCheck: begin
          if (mismatch) begin
            bit_err_d = 1'b1;
            state_d   = StHunt;
            phase_d   = 3'd0;
          end else begin
            phase_d = phase_inc;
            if (last_bit) begin
              good_d = good_q + 4'd1;
              if (good_d == LockFramesW) begin
                state_d = StLocked;
                bad_d   = 4'd0;
                perr_d  = 1'b0;
              end
            end
          end
        end

        StLocked: begin
          phase_d = phase_inc;
          if (mismatch) begin
            bit_err_d = 1'b1;
            err_inc   = 1'b1;
            perr_d    = 1'b1;
          end
          if (last_bit) begin
            frame_start_d = 1'b1;
            perr_d        = 1'b0;
            // An error on the boundary bit itself still marks this period bad.
            bad_d = (perr_q || mismatch) ? bad_q + 4'd1 : 4'd0;
            if (bad_d == UnlockBadW) begin
              state_d = StHunt;
              phase_d = 3'd0;
            end
          end
        end

        default: begin
          state_d = StHunt;
          phase_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StHunt;
      win_q         <= '0;
      fill_q        <= 3'd0;
      phase_q       <= 3'd0;
      good_q        <= 4'd0;
      bad_q         <= 4'd0;
      perr_q        <= 1'b0;
      bit_err_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      fill_q        <= fill_d;
      phase_q       <= phase_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      perr_q        <= perr_d;
      bit_err_q     <= bit_err_d;
      frame_start_q <= frame_start_d;
    end
  end

  seq7_err_counter #(
    .ERRW(ERRW)
  ) u_err_counter (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (err_inc),
    .count_o(err_count)
  );

  assign locked      = (state_q == StLocked);
  assign phase       = phase_q;
  assign bit_err     = bit_err_q;
  assign frame_start = frame_start_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_seq7_checker.sv
// Scoreboard bench for seq7_checker: the stimulus side pushes the expected
// registered outputs for every driven cycle; a monitor pops and compares after
// each rising edge. Hand-computed checkpoints cover lock/unlock bit positions.
module tb_seq7_checker;

  localparam int ERRW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            din = 1'b0;
  logic            din_valid = 1'b0;
  logic            locked;
  logic [2:0]      phase;
  logic            bit_err;
  logic            frame_start;
  logic [ERRW-1:0] err_count;
  logic [2:0]      state_o;

  seq7_checker #(
    .LOCK_FRAMES(2),
    .UNLOCK_BAD (3),
    .ERRW       (ERRW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .locked     (locked),
    .phase      (phase),
    .bit_err    (bit_err),
    .frame_start(frame_start),
    .err_count  (err_count),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            locked;
    logic [2:0]      phase;
    logic            bit_err;
    logic            frame_start;
    logic [ERRW-1:0] err_count;
    logic [2:0]      state;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Generator sequence, written out by hand.
  int tbpat[7] = '{1, 1, 0, 1, 0, 0, 0};
  int tx_ph = 0;

  // Reference model: 0=HUNT 1=CHECK 2=LOCKED
  int m_state, m_fill, m_phase, m_good, m_bad, m_err;
  bit m_perr;
  logic [6:0] m_hist;

  function automatic void model_reset();
    m_state = 0; m_fill = 0; m_phase = 0; m_good = 0; m_bad = 0; m_err = 0;
    m_perr = 1'b0; m_hist = '0;
  endfunction

  function automatic void model_step(logic v, logic d);
    exp_t e;
    logic wrong;
    e = '0;
    if (v) begin
      m_hist = {m_hist[5:0], d};
      if (m_fill < 7) m_fill++;
      wrong = (int'(d) != tbpat[m_phase]);
      case (m_state)
        0: if (m_fill == 7 && m_hist == 7'b1101000) begin
             m_state = 1; m_phase = 0; m_good = 0;
           end
        1: if (wrong) begin
             e.bit_err = 1'b1; m_state = 0; m_phase = 0;
           end else begin
             if (m_phase == 6) begin
               m_good++;
               if (m_good == 2) begin m_state = 2; m_bad = 0; m_perr = 0; end
             end
             m_phase = (m_phase + 1) % 7;
           end
        default: begin
          if (wrong) begin
            e.bit_err = 1'b1;
            if (m_err < (1 << ERRW) - 1) m_err++;
            m_perr = 1'b1;
          end
          if (m_phase == 6) begin
            e.frame_start = 1'b1;
            if (m_perr) m_bad++; else m_bad = 0;
            m_perr = 1'b0;
            if (m_bad == 3) m_state = 0;
          end
          m_phase = (m_phase + 1) % 7;
        end
      endcase
    end
    e.locked    = (m_state == 2);
    e.phase     = 3'(m_phase);
    e.err_count = ERRW'(m_err);
    e.state     = (m_state == 0) ? 3'b001 : (m_state == 1) ? 3'b010 : 3'b100;
    exp_q.push_back(e);
  endfunction

  // Monitor: one expected entry per driven edge.
  initial begin
    exp_t a, x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a = '{locked, phase, bit_err, frame_start, err_count, state_o};
        n_tests++;
        if (a !== x) begin
          n_fail++;
          $display("FAIL sb t=%0t got lk=%0b ph=%0d be=%0b fs=%0b ec=%0d st=%b want lk=%0b ph=%0d be=%0b fs=%0b ec=%0d st=%b",
                   $time, a.locked, a.phase, a.bit_err, a.frame_start, a.err_count, a.state,
                   x.locked, x.phase, x.bit_err, x.frame_start, x.err_count, x.state);
        end
      end
    end
  end

  task automatic hc(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic v, input logic d);
    @(negedge clk);
    din_valid = v;
    din       = d;
    model_step(v, d);
    @(posedge clk);
    #2;
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) begin
      send(1'b1, 1'(tbpat[tx_ph]));
      tx_ph = (tx_ph + 1) % 7;
    end
  endtask

  task automatic send_err();
    send(1'b1, ~1'(tbpat[tx_ph]));
    tx_ph = (tx_ph + 1) % 7;
  endtask

  // Invalid cycle carrying the wrong bit, which must be ignored.
  task automatic idle();
    send(1'b0, ~1'(tbpat[tx_ph]));
  endtask

  task automatic bad_periods(input int n);
    for (int p = 0; p < n; p++) begin
      send_clean(2);
      send_err();
      send_clean(4);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    din_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tx_ph = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    hc("rst_state", int'(state_o), 1);
    hc("rst_locked", int'(locked), 0);
    hc("rst_phase", int'(phase), 0);
    hc("rst_bit_err", int'(bit_err), 0);
    hc("rst_frame_start", int'(frame_start), 0);
    hc("rst_err_count", int'(err_count), 0);
    do_reset();

    // Clean stream from phase 0.
    send_clean(6);  hc("hunt_after6", int'(state_o), 1);
    send_clean(1);  hc("check_after7", int'(state_o), 2);
    send_clean(13); hc("unlocked_after20", int'(locked), 0);
    send_clean(1);  hc("locked_after21", int'(locked), 1);
    send_clean(7);  hc("frame_start_p6", int'(frame_start), 1);
    hc("clean_err_count", int'(err_count), 0);

    // Single error at phase 3 while locked.
    send_clean(3);
    send_err();
    hc("single_bit_err", int'(bit_err), 1);
    hc("single_err_count", int'(err_count), 1);
    hc("single_still_locked", int'(locked), 1);
    send_clean(3);
    send_clean(7);
    hc("locked_after_clean", int'(locked), 1);

    // Three consecutive errored periods drop lock.
    bad_periods(2);
    hc("locked_after_2bad", int'(locked), 1);
    bad_periods(1);
    hc("unlocked_after_3bad", int'(locked), 0);
    hc("err_count_after_3bad", int'(err_count), 4);
    send_clean(6);  hc("rehunt_after6", int'(state_o), 1);
    send_clean(1);  hc("reacq", int'(state_o), 2);
    send_clean(13); hc("relock_not_yet", int'(locked), 0);
    send_clean(1);  hc("relock_14", int'(locked), 1);

    // Error during CHECK leaves err_count untouched.
    bad_periods(3);
    hc("err_count_7", int'(err_count), 7);
    send_clean(7);  hc("check_again", int'(state_o), 2);
    send_clean(7);
    send_clean(4);
    send_err();
    hc("check_bit_err", int'(bit_err), 1);
    hc("check_to_hunt", int'(state_o), 1);
    hc("check_err_unchanged", int'(err_count), 7);
    send_clean(2);

    // Alternating din_valid.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send_clean(1);
      idle();
    end
    hc("toggle_unlocked_20", int'(locked), 0);
    send_clean(1);
    hc("toggle_locked_21", int'(locked), 1);
    idle();
    hc("toggle_hold", int'(locked), 1);

    // Stream starting mid-pattern.
    do_reset();
    tx_ph = 2;
    send_clean(11); hc("mid_hunt_11", int'(state_o), 1);
    send_clean(1);  hc("mid_check_12", int'(state_o), 2);
    send_clean(13); hc("mid_unlocked_25", int'(locked), 0);
    send_clean(1);  hc("mid_locked_26", int'(locked), 1);
    hc("mid_phase0", int'(phase), 0);
    send_clean(3);  hc("mid_phase3", int'(phase), 3);

    // Asynchronous reset while locked.
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    hc("async_rst_locked", int'(locked), 0);
    hc("async_rst_phase", int'(phase), 0);
    hc("async_rst_state", int'(state_o), 1);
    @(negedge clk);
    reset = 1'b1;
    tx_ph = 0;
    send_clean(20); hc("post_rst_unlocked_20", int'(locked), 0);
    send_clean(1);  hc("post_rst_locked_21", int'(locked), 1);

    @(negedge clk);
    @(negedge clk);
    hc("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
